// File: rtl/laser_seq_pkg.sv
// -----------------------------------------------------------------------------
// laser_seq_pkg
// Shared definitions for the laser arm sequencer:
//   - state_e       : FSM state encodings (also the state_o readback value)
//   - FL_*          : bit positions inside the 5-bit fault_latched vector
//   - CNT_W         : width of every internal cycle counter
//   - last_count()  : terminal count for a cycle parameter (0 behaves as 1)
//   - sat_inc()     : saturating counter increment
// -----------------------------------------------------------------------------
package laser_seq_pkg;

  localparam int CNT_W = 32;
  localparam int FL_W  = 5;

  localparam int FL_PW   = 0;
  localparam int FL_RATE = 1;
  localparam int FL_PEAK = 2;
  localparam int FL_PWR  = 3;
  localparam int FL_WDT  = 4;

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_PG_WAIT  = 3'd1,
    ST_SETTLE   = 3'd2,
    ST_ARMED    = 3'd3,
    ST_FAULT    = 3'd4,
    ST_COOLDOWN = 3'd5
  } state_e;

  // Counters start at 0 on state entry, so an N-cycle wait ends when the
  // counter holds N-1. A zero parameter is treated as a one-cycle wait.
  function automatic logic [CNT_W-1:0] last_count(input int unsigned cycles);
    if (cycles == 32'd0) begin
      return {CNT_W{1'b0}};
    end else begin
      return CNT_W'(cycles - 32'd1);
    end
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// -----------------------------------------------------------------------------
// seq_watchdog
// Kick/reload watchdog used while the laser is armed.
// Ports:
//   clk_i     system clock
//   rst_i     asynchronous active-high reset
//   run_i     counter runs while high, held at zero while low
//   kick_i    single-cycle kick, reloads the counter
//   expire_o  high in the cycle whose edge would complete WDT_CYCLES
//             cycles without a kick (combinational, feeds the FSM)
// -----------------------------------------------------------------------------
module seq_watchdog
  import laser_seq_pkg::*;
#(
  parameter int unsigned WDT_CYCLES = 32'd25000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  input  logic kick_i,
  output logic expire_o
);

  localparam logic [CNT_W-1:0] WDT_LAST = last_count(WDT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Hold at zero when not running so ARMED entry always starts a fresh count;
  // a kick in the expiry cycle wins over the expiry.
  always_comb begin
    cnt_d    = sat_inc(cnt_q);
    expire_o = 1'b0;
    if (!run_i || kick_i) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      expire_o = (cnt_q >= WDT_LAST);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/laser_arm_sequencer.sv
// -----------------------------------------------------------------------------
// laser_arm_sequencer
// Owns the decision of when the laser may emit: power-up debounce, settle,
// arming, fault latching/shutdown, host fault clear and cooldown.
// Optional feature macro: LASER_SEQ_WATCHDOG_EN (armed-state host watchdog).
// Ports:
//   clk, rst        25 MHz clock, asynchronous active-high reset
//   enable_req      host enable level
//   clear_req       host fault-clear pulse (honoured only in FAULT with
//                   enable_req low)
//   wdt_kick        host watchdog kick pulse (watchdog builds only)
//   pwr_good        synchronized laser supply good
//   fault_in[2:0]   checker fail levels: pulse width, rate, peak current
//   laser_pwr_en    laser supply enable (registered)
//   ta_shutdown     TA shutdown, 1 inhibits emission (registered)
//   armed           high only in ARMED (registered)
//   clear_out       one-cycle clear pulse to the checkers (registered)
//   fault_latched   {wdt, pwr lost, peak, rate, pw} latched faults
//   state_o         current state encoding
// -----------------------------------------------------------------------------
module laser_arm_sequencer
  import laser_seq_pkg::*;
#(
  parameter int unsigned PG_DEBOUNCE     = 32'd250,
  parameter int unsigned SETTLE_CYCLES   = 32'd25000,
  parameter int unsigned COOLDOWN_CYCLES = 32'd250000,
  parameter int unsigned WDT_CYCLES      = 32'd25000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable_req,
  input  logic            clear_req,
  input  logic            wdt_kick,
  input  logic            pwr_good,
  input  logic [2:0]      fault_in,
  output logic            laser_pwr_en,
  output logic            ta_shutdown,
  output logic            armed,
  output logic            clear_out,
  output logic [FL_W-1:0] fault_latched,
  output logic [2:0]      state_o
);

  localparam logic [CNT_W-1:0] PG_LAST     = last_count(PG_DEBOUNCE);
  localparam logic [CNT_W-1:0] SETTLE_LAST = last_count(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] COOL_LAST   = last_count(COOLDOWN_CYCLES);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [FL_W-1:0]   fl_q, fl_d;
  logic              pwr_en_q, pwr_en_d;
  logic              shdn_q, shdn_d;
  logic              armed_q, armed_d;
  logic              clr_q, clr_d;
  logic              wdt_run_s;
  logic              wdt_expire_s;
  logic [FL_W-1:0]   src_s;

  assign wdt_run_s = (state_q == ST_ARMED);

`ifdef LASER_SEQ_WATCHDOG_EN
  seq_watchdog #(
    .WDT_CYCLES (WDT_CYCLES)
  ) u_wdt (
    .clk_i    (clk),
    .rst_i    (rst),
    .run_i    (wdt_run_s),
    .kick_i   (wdt_kick),
    .expire_o (wdt_expire_s)
  );
`else
  logic unused_wdt_s;
  assign unused_wdt_s = wdt_kick ^ wdt_run_s;
  assign wdt_expire_s = 1'b0;
`endif

  // Fault sources visible this cycle; the watchdog bit can only be set in ARMED.
  assign src_s = {wdt_expire_s, ~pwr_good, fault_in};

  // Next-state, counter, fault latch and next-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = sat_inc(cnt_q);
    fl_d    = fl_q;
    clr_d   = 1'b0;

    case (state_q)
      ST_OFF: begin
        // Faults here only block arming; nothing latches.
        if (enable_req && (fl_q == {FL_W{1'b0}}) && (fault_in == 3'b000)) begin
          state_d = ST_PG_WAIT;
        end else begin
          state_d = ST_OFF;
        end
      end
      ST_PG_WAIT: begin
        if (!pwr_good) begin
          cnt_d = {CNT_W{1'b0}};
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
        if (!enable_req) begin
          state_d = ST_OFF;
        end else if (pwr_good && (cnt_q >= PG_LAST)) begin
          state_d = ST_SETTLE;
        end else begin
          state_d = ST_PG_WAIT;
        end
      end
      ST_SETTLE: begin
        if (|src_s) begin
          fl_d    = fl_q | src_s;
          state_d = ST_FAULT;
        end else if (!enable_req) begin
          state_d = ST_COOLDOWN;
        end else if (cnt_q >= SETTLE_LAST) begin
          state_d = ST_ARMED;
        end else begin
          state_d = ST_SETTLE;
        end
      end
      ST_ARMED: begin
        if (|src_s) begin
          fl_d    = fl_q | src_s;
          state_d = ST_FAULT;
        end else if (!enable_req) begin
          state_d = ST_COOLDOWN;
        end else begin
          state_d = ST_ARMED;
        end
      end
      ST_FAULT: begin
        // A clear in the same cycle as a new source wins: the checkers are
        // cleared too, and anything still high re-latches after cooldown.
        if (clear_req && !enable_req) begin
          fl_d    = {FL_W{1'b0}};
          clr_d   = 1'b1;
          state_d = ST_COOLDOWN;
        end else begin
          fl_d    = fl_q | src_s;
          state_d = ST_FAULT;
        end
      end
      ST_COOLDOWN: begin
        if (cnt_q >= COOL_LAST) begin
          if (|fault_in) begin
            fl_d    = fl_q | {2'b00, fault_in};
            state_d = ST_FAULT;
          end else begin
            state_d = ST_OFF;
          end
        end else begin
          state_d = ST_COOLDOWN;
        end
      end
      default: begin
        state_d = ST_FAULT;
      end
    endcase

    if (state_d != state_q) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_d;
    end

    // Outputs are decoded from the next state so they change on the same edge.
    pwr_en_d  = (state_d == ST_SETTLE) || (state_d == ST_ARMED);
    shdn_d    = (state_d != ST_ARMED);
    armed_d   = (state_d == ST_ARMED);
  end

  // State, counter, fault latch and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_OFF;
      cnt_q    <= {CNT_W{1'b0}};
      fl_q     <= {FL_W{1'b0}};
      pwr_en_q <= 1'b0;
      shdn_q   <= 1'b1;
      armed_q  <= 1'b0;
      clr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      fl_q     <= fl_d;
      pwr_en_q <= pwr_en_d;
      shdn_q   <= shdn_d;
      armed_q  <= armed_d;
      clr_q    <= clr_d;
    end
  end

  assign laser_pwr_en  = pwr_en_q;
  assign ta_shutdown   = shdn_q;
  assign armed         = armed_q;
  assign clear_out     = clr_q;
  assign fault_latched = fl_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_laser_arm_sequencer.sv
// -----------------------------------------------------------------------------
// tb_laser_arm_sequencer
// Directed bench: a per-cycle vector table for the arm / fault / clear /
// cooldown path, followed by hand-written sequences for power-good debounce,
// power loss in SETTLE, cooldown re-latch, watchdog and asynchronous reset.
// Expected pwr_en / ta_shutdown / armed follow from the expected state.
// -----------------------------------------------------------------------------
module tb_laser_arm_sequencer;

  localparam int unsigned PG = 32'd4;
  localparam int unsigned SC = 32'd8;
  localparam int unsigned CD = 32'd6;
  localparam int unsigned WD = 32'd20;
  localparam int NV = 26;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable_req = 1'b0;
  logic       clear_req = 1'b0;
  logic       wdt_kick = 1'b0;
  logic       pwr_good = 1'b0;
  logic [2:0] fault_in = 3'b000;
  logic       laser_pwr_en, ta_shutdown, armed, clear_out;
  logic [4:0] fault_latched;
  logic [2:0] state_o;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic       en;
    logic       clr;
    logic       pg;
    logic [2:0] flt;
    logic [2:0] st;
    logic       co;
    logic [4:0] fl;
  } vec_t;

  vec_t vecs [NV];

  laser_arm_sequencer #(
    .PG_DEBOUNCE     (PG),
    .SETTLE_CYCLES   (SC),
    .COOLDOWN_CYCLES (CD),
    .WDT_CYCLES      (WD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable_req    (enable_req),
    .clear_req     (clear_req),
    .wdt_kick      (wdt_kick),
    .pwr_good      (pwr_good),
    .fault_in      (fault_in),
    .laser_pwr_en  (laser_pwr_en),
    .ta_shutdown   (ta_shutdown),
    .armed         (armed),
    .clear_out     (clear_out),
    .fault_latched (fault_latched),
    .state_o       (state_o)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic en, input logic clr, input logic pg,
                              input logic [2:0] flt, input logic [2:0] st,
                              input logic co, input logic [4:0] fl);
    vec_t v;
    v.en = en; v.clr = clr; v.pg = pg; v.flt = flt;
    v.st = st; v.co = co; v.fl = fl;
    return v;
  endfunction

  task automatic chk(input string name, input logic [2:0] st, input logic co,
                     input logic [4:0] fl);
    logic [11:0] exp_v;
    logic [11:0] act_v;
    exp_v = {st, (st == 3'd2) || (st == 3'd3), st != 3'd3, st == 3'd3, co, fl};
    act_v = {state_o, laser_pwr_en, ta_shutdown, armed, clear_out, fault_latched};
    n_vec++;
    if (act_v !== exp_v) begin
      n_err++;
      $display("FAIL %s: {st,pwr,shdn,arm,clr,fl} got=%b exp=%b", name, act_v, exp_v);
    end
  endtask

  task automatic cyc(input logic en, input logic clr, input logic kick,
                     input logic pg, input logic [2:0] flt);
    enable_req = en;
    clear_req  = clr;
    wdt_kick   = kick;
    pwr_good   = pg;
    fault_in   = flt;
    @(posedge clk);
    #1;
  endtask

  // From OFF with pwr_good steady: SETTLE after 1+PG edges, ARMED after +SC.
  task automatic arm();
    repeat (12) cyc(1'b1, 1'b0, 1'b0, 1'b1, 3'b000);
    chk("arm_settle", 3'd2, 1'b0, 5'b00000);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 3'b000);
    chk("arm_armed", 3'd3, 1'b0, 5'b00000);
  endtask

  task automatic clear_to_off(input string name);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 3'b000);
    chk({name, "_clr"}, 3'd5, 1'b1, 5'b00000);
    repeat (6) cyc(1'b0, 1'b0, 1'b0, 1'b1, 3'b000);
    chk({name, "_off"}, 3'd0, 1'b0, 5'b00000);
  endtask

  initial begin
    // en, clr, pg, fault_in -> state, clear_out, fault_latched
    vecs[0] = mk(1'b1, 1'b0, 1'b1, 3'b000, 3'd1, 1'b0, 5'b00000);
    for (int i = 1; i <= 3; i++) vecs[i] = mk(1'b1, 1'b0, 1'b1, 3'b000, 3'd1, 1'b0, 5'b00000);
    vecs[4] = mk(1'b1, 1'b0, 1'b1, 3'b000, 3'd2, 1'b0, 5'b00000);
    for (int i = 5; i <= 11; i++) vecs[i] = mk(1'b1, 1'b0, 1'b1, 3'b000, 3'd2, 1'b0, 5'b00000);
    vecs[12] = mk(1'b1, 1'b0, 1'b1, 3'b000, 3'd3, 1'b0, 5'b00000);
    vecs[13] = mk(1'b1, 1'b0, 1'b1, 3'b100, 3'd4, 1'b0, 5'b00100);
    vecs[14] = mk(1'b1, 1'b1, 1'b1, 3'b000, 3'd4, 1'b0, 5'b00100);
    vecs[15] = mk(1'b0, 1'b0, 1'b1, 3'b000, 3'd4, 1'b0, 5'b00100);
    vecs[16] = mk(1'b0, 1'b1, 1'b1, 3'b000, 3'd5, 1'b1, 5'b00000);
    vecs[17] = mk(1'b0, 1'b0, 1'b1, 3'b000, 3'd5, 1'b0, 5'b00000);
    for (int i = 18; i <= 21; i++) vecs[i] = mk(1'b1, 1'b0, 1'b1, 3'b000, 3'd5, 1'b0, 5'b00000);
    vecs[22] = mk(1'b1, 1'b1, 1'b1, 3'b000, 3'd0, 1'b0, 5'b00000);
    vecs[23] = mk(1'b1, 1'b0, 1'b1, 3'b010, 3'd0, 1'b0, 5'b00000);
    vecs[24] = mk(1'b1, 1'b0, 1'b1, 3'b000, 3'd1, 1'b0, 5'b00000);
    vecs[25] = mk(1'b0, 1'b0, 1'b1, 3'b000, 3'd0, 1'b0, 5'b00000);

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", 3'd0, 1'b0, 5'b00000);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      cyc(vecs[i].en, vecs[i].clr, 1'b0, vecs[i].pg, vecs[i].flt);
      chk($sformatf("vec%0d", i), vecs[i].st, vecs[i].co, vecs[i].fl);
    end

    // pwr_good low every third cycle never lets the debounce complete.
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 3'b000);
    chk("pg_enter", 3'd1, 1'b0, 5'b00000);
    for (int i = 0; i < 30; i++) begin
      cyc(1'b1, 1'b0, 1'b0, (i % 3) != 2, 3'b000);
      chk("pg_glitch", 3'd1, 1'b0, 5'b00000);
    end
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b1, 3'b000);
    chk("pg_hold", 3'd1, 1'b0, 5'b00000);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 3'b000);
    chk("pg_settle", 3'd2, 1'b0, 5'b00000);

    // Power loss in SETTLE, more sources OR in, clear with a source still high.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
    chk("settle_pwr_loss", 3'd4, 1'b0, 5'b01000);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 3'b001);
    chk("fault_or", 3'd4, 1'b0, 5'b01001);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 3'b001);
    chk("clear_pulse", 3'd5, 1'b1, 5'b00000);
    repeat (5) cyc(1'b0, 1'b0, 1'b0, 1'b1, 3'b001);
    chk("cooldown_hold", 3'd5, 1'b0, 5'b00000);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 3'b001);
    chk("cooldown_relatch", 3'd4, 1'b0, 5'b00001);
    clear_to_off("relatch");

    // Fault beats a simultaneous enable drop in ARMED.
    arm();
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 3'b010);
    chk("fault_prio", 3'd4, 1'b0, 5'b00010);
    clear_to_off("prio");

    arm();
`ifdef LASER_SEQ_WATCHDOG_EN
    repeat (19) cyc(1'b1, 1'b0, 1'b0, 1'b1, 3'b000);
    chk("wdt_hold", 3'd3, 1'b0, 5'b00000);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 3'b000);
    chk("wdt_expire", 3'd4, 1'b0, 5'b10000);
    clear_to_off("wdt");
    arm();
    for (int i = 0; i < 60; i++) begin
      cyc(1'b1, 1'b0, (i % 15) == 14, 1'b1, 3'b000);
      chk("wdt_kicked", 3'd3, 1'b0, 5'b00000);
    end
`else
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 3'b000);
      chk("no_wdt", 3'd3, 1'b0, 5'b00000);
    end
`endif
    // Disarm goes through a full cooldown.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 3'b000);
    chk("disarm", 3'd5, 1'b0, 5'b00000);
    repeat (5) cyc(1'b0, 1'b0, 1'b0, 1'b1, 3'b000);
    chk("disarm_cool", 3'd5, 1'b0, 5'b00000);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 3'b000);
    chk("disarm_off", 3'd0, 1'b0, 5'b00000);

    // Reset between clock edges while ARMED.
    arm();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async", 3'd0, 1'b0, 5'b00000);
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 3'b000);
    chk("rst_restart", 3'd1, 1'b0, 5'b00000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/laser_arm_sequencer.md
# laser_arm_sequencer

- Sequences laser power-up, arming, fault shutdown and recovery for the safety FPGA.
- Sits between the I2C register file (enable, clear and watchdog-kick requests) and the laser driver outputs: power enable and TA shutdown.
- Consumes the latched fail flags from the pulse-width, rate and peak-current checkers and the board `pwr_good`, and owns the single decision of when the laser may emit.

## Interface
Parameters:
- `PG_DEBOUNCE`, 250 — consecutive `pwr_good` cycles required before settling.
- `SETTLE_CYCLES`, 25000 — cycles with power enabled but TA held in shutdown (1 ms at 25 MHz).
- `COOLDOWN_CYCLES`, 250000 — mandatory off time after disarm or fault clear (10 ms).
- `WDT_CYCLES`, 25000000 — maximum cycles between watchdog kicks while armed (1 s).

Ports:
- `clk`  in  1  system clock (25 MHz domain).
- `rst`  in  1  asynchronous, active-high reset.
- `enable_req`  in  1  level; host requests laser enabled.
- `clear_req`  in  1  single-cycle pulse; host requests fault clear.
- `wdt_kick`  in  1  single-cycle pulse; host watchdog kick.
- `pwr_good`  in  1  laser supply good, already synchronized.
- `fault_in`  in  3  [0] pulse-width fail, [1] rate fail, [2] peak-current fail; synchronous levels.
- `laser_pwr_en`  out  1  laser supply enable.
- `ta_shutdown`  out  1  TA shutdown; 1 = emission inhibited.
- `armed`  out  1  high only in ARMED.
- `clear_out`  out  1  one-cycle clear pulse to the checkers.
- `fault_latched`  out  5  [0..2] mirror `fault_in`, [3] power lost, [4] watchdog.
- `state_o`  out  3  current state encoding, for status readback.

## Operation
States, with their encoding:
- OFF=0: `laser_pwr_en`=0, `ta_shutdown`=1.
  - `enable_req`=1, `fault_latched`==0 and `fault_in`==0 → PG_WAIT.
- PG_WAIT=1: outputs as OFF.
  - A counter increments while `pwr_good`=1 and clears when `pwr_good`=0.
  - Counter reaches `PG_DEBOUNCE` → SETTLE.
  - `enable_req`=0 → OFF.
- SETTLE=2: `laser_pwr_en`=1, `ta_shutdown`=1.
  - After `SETTLE_CYCLES` cycles → ARMED.
  - `pwr_good`=0 → FAULT with bit 3 set.
  - Any `fault_in` → FAULT.
  - `enable_req`=0 → COOLDOWN.
- ARMED=3: `laser_pwr_en`=1, `ta_shutdown`=0, `armed`=1.
  - Any `fault_in` bit, `pwr_good`=0 or watchdog expiry → FAULT.
  - `enable_req`=0 → COOLDOWN.
- FAULT=4: `laser_pwr_en`=0, `ta_shutdown`=1.
  - `fault_latched` ORs in every new source each cycle.
  - `clear_req` with `enable_req`=0 → `clear_out` pulse, `fault_latched` cleared, → COOLDOWN.
  - `clear_req` with `enable_req`=1 is ignored.
- COOLDOWN=5: outputs as OFF; `enable_req` is ignored.
  - After `COOLDOWN_CYCLES` cycles, any `fault_in` still high → FAULT (re-latched); otherwise → OFF.

Rules:
- Faults latch only in SETTLE, ARMED and FAULT. In OFF and PG_WAIT they only block arming.
- Priority in SETTLE and ARMED: fault > `enable_req` drop > count expiry.
- `clear_req` outside FAULT is ignored and produces no `clear_out`.
- Counters are 32-bit and saturate; they reset on every state entry. Parameter value 0 is treated as 1.
- Encodings 6 and 7 are illegal and go to FAULT.

## Timing
- All outputs are registered.
- A state transition takes effect at the clock edge where its condition is sampled; outputs reflect the new state immediately after that edge.
- `fault_in` high sampled at edge k → `ta_shutdown`=1 and `laser_pwr_en`=0 after edge k. Latency is one cycle from the input.
- `clear_out` is high for exactly the cycle following the sampled `clear_req`.
- Minimum cycle counts:
  - OFF→ARMED: 1 + `PG_DEBOUNCE` + `SETTLE_CYCLES`.
  - Disarm→re-enable: `COOLDOWN_CYCLES` + 1.
- Reset values:
  - state OFF, `state_o`=0.
  - `laser_pwr_en`=0, `ta_shutdown`=1.
  - `armed`=0, `clear_out`=0, `fault_latched`=0.
- Reset asserted mid-operation forces these values asynchronously; no sequencing on release.

## Configuration
- `LASER_SEQ_WATCHDOG_EN` defined:
  - Watchdog counter runs only in ARMED.
  - The counter reloads on ARMED entry and on each `wdt_kick`.
  - Reaching `WDT_CYCLES` → FAULT with bit 4 set.
- Undefined: `fault_latched[4]` is tied 0, `wdt_kick` is unused and `WDT_CYCLES` is ignored.

## Structure
- Package `laser_seq_pkg` holds:
  - state encodings;
  - `fault_latched` bit indices (PW, RATE, PEAK, PWR, WDT) and the 5-bit width constant;
  - counter width.
- One sub-module, `seq_watchdog`: kick/reload counter with an expiry output. It is instantiated only under the macro.

## Test plan
All cases use `PG_DEBOUNCE`=4, `SETTLE_CYCLES`=8, `COOLDOWN_CYCLES`=6, `WDT_CYCLES`=20.
- `pwr_good`=1, `enable_req` rises → `laser_pwr_en` rises 5 cycles later, `ta_shutdown` falls 8 cycles after that, and `armed`=1.
- ARMED, `fault_in`=3'b100 for one cycle → next cycle `ta_shutdown`=1, `laser_pwr_en`=0, `fault_latched`=5'b00100; state stays FAULT with `enable_req`=1.
- FAULT, drop `enable_req`, pulse `clear_req`, then drop `fault_in` → one-cycle `clear_out`, `fault_latched`=0, COOLDOWN for 6 cycles, then OFF.
- PG_WAIT with `pwr_good` glitching low every 3rd cycle → never reaches SETTLE. SETTLE with `pwr_good` dropped → FAULT with bit 3.
- Macro on, ARMED, no kicks → FAULT with bit 4 after 20 cycles. With kicks every 15 cycles → stays ARMED.
- `rst` pulsed while ARMED → outputs return to their reset values asynchronously; FSM restarts from OFF.
